est_sync_entrada_seq: RTL and testbench
=======================================

# est_sync_entrada_seq

Parametrised, clocked token source for the head of the asynchronous pipeline. It drives a four-phase bundled-data handshake (req_out/ack_next) into the first stage and emits a programmable arithmetic sequence of WIDTH-bit tokens: START, START+STEP, …, either once (COUNT tokens, then done) or looping forever. ack_next comes from the self-timed domain and is synchronised internally. data_out is forced to zero while in reset.

## Interface
- WIDTH, 8: token width in bits.
- START, 8'h56: first token value; truncated to WIDTH.
- STEP, 1: increment between consecutive tokens; truncated to WIDTH.
- COUNT, 4: tokens per sequence, ≥1.
- LOOP, 0: 0 = stop after COUNT tokens; 1 = restart at START indefinitely.
- ACK_SYNC, 2: synchroniser flops on ack_next, ≥2.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  start/continue request; level-sensitive.
- ack_next  in  1  acknowledge from the downstream asynchronous stage; asynchronous to clk.
- req_out  out  1  four-phase request to the downstream stage.
- data_out  out  WIDTH  bundled data; stable whenever req_out=1.
- idx  out  clog2(COUNT) (min 1)  index of the token currently on data_out.
- done  out  1  sequence complete (LOOP=0 only).

## Operation
- Reset: asynchronous; state IDLE, req_out=0, data_out=0, idx=0, done=0, synchroniser flops cleared.
- ack_s = ack_next after ACK_SYNC flops. The FSM only ever uses ack_s.
- Token value: data_out = (START + idx*STEP) mod 2^WIDTH.
- FSM:
  - IDLE: req_out=0. If en=1, load idx=0 and data_out=START, then go to SETUP.
  - SETUP: req_out=0, data held. If ack_s=0, go to REQ; otherwise wait.
  - REQ: req_out=1. Wait for ack_s=1, then go to RTZ.
  - RTZ: req_out=0. Wait for ack_s=0, then:
    - if en=0: go to IDLE and reset idx to 0 (abort);
    - else if idx=COUNT-1 and LOOP=0: go to DONE;
    - else: idx advances (to 0 if idx=COUNT-1), data_out is updated to match, and the FSM goes to SETUP.
  - DONE: done=1, req_out=0, data_out holds the last token. When en=0, go to IDLE and clear done.
- en is sampled only in IDLE, at RTZ exit, and in DONE. Dropping en during REQ never truncates a handshake.
- Index wrap: idx wraps from COUNT-1 to 0; the data arithmetic wraps modulo 2^WIDTH.
- Reset asserted mid-handshake forces req_out=0 immediately. Downstream stages share rst_n, so this breaking of four-phase protocol is acceptable.

## Timing
- Start latency: en=1 sampled at edge k in IDLE gives data_out valid after edge k and req_out=1 after edge k+1. Data leads req by at least 1 cycle.
- data_out changes only on the SETUP entry edge, never while req_out=1. This satisfies the bundling constraint.
- Ack to req fall: ack_next rising leads to ack_s=1 after ACK_SYNC edges, and req_out falls on the following edge.
- Minimum clocks per token, with an instant downstream: 2·(ACK_SYNC+1)+1.
- done rises on the edge after the final RTZ completes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package est_pkg holds:
  - the FSM state typedef (IDLE, SETUP, REQ, RTZ, DONE), 3-bit encoding;
  - a localparam helper for index width (clog2 with minimum 1).
- One sub-module, est_sync_ack: an ACK_SYNC-deep flop chain with asynchronous active-low clear, output ack_s. It is reused by later clocked/async bridges.
- The core is a single FSM, an index counter, and a data register (START + idx*STEP computed from idx, registered).

## Test plan
- Defaults (WIDTH=8, START=8'h56, STEP=1, COUNT=4, LOOP=0), en held high, downstream model acks 3 cycles after req → tokens 56, 57, 58, 59 in order. done=1 after the 4th RTZ; req_out stays 0 afterwards. Drop en → IDLE, done=0.
- LOOP=1, COUNT=3, START=8'hFE, STEP=1 → FE, FF, 00, FE, FF, 00… idx wraps 2→0; data wraps mod 256.
- Reset: assert rst_n=0 while req_out=1 → req_out, data_out, idx and done are all 0 at once, without a clock edge. Release → IDLE.
- en dropped during REQ → the handshake completes, then the FSM returns to IDLE with idx=0. Re-raising en restarts at START.
- ack_next held high before start → the FSM stays in SETUP with req_out=0 until ack_next falls. The bench checks that data_out never changes while req_out=1 and that the data-before-req gap is at least 1 cycle for every token.

Source files
------------

// File: rtl/est_sync_entrada_seq_pkg.sv
// Shared definitions for the clocked token source and its ack synchroniser.
//   state_e    : FSM state encoding (3 bits).
//   idx_width  : index width helper, clog2(count) with a minimum of 1.
package est_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StReq   = 3'd2,
    StRtz   = 3'd3,
    StDone  = 3'd4
  } state_e;

  function automatic int unsigned idx_width(input int unsigned count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/est_sync_entrada_seq_if.sv
// Handshake/bus bundle between the token source and the first async stage.
//   en       : start/continue request (level)
//   ack_next : acknowledge from the downstream self-timed stage
//   req_out  : four-phase request
//   data_out : bundled data, stable while req_out=1
//   idx      : index of the token on data_out
//   done     : sequence complete
interface est_sync_entrada_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 2
);
  logic             en;
  logic             ack_next;
  logic             req_out;
  logic [WIDTH-1:0] data_out;
  logic [IDX_W-1:0] idx;
  logic             done;

  // master: the token source; slave: its environment (downstream + control)
  modport master (input en, input ack_next, output req_out, output data_out, output idx,
                  output done);
  modport slave  (output en, output ack_next, input req_out, input data_out, input idx,
                  input done);
endinterface

// File: rtl/est_sync_ack.sv
// Depth-flop synchroniser for an acknowledge arriving from a self-timed domain.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low clear of every stage
//   ack_i   : asynchronous acknowledge
//   ack_s_o : synchronised acknowledge
module est_sync_ack #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ack_i,
  output logic ack_s_o
);

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Depth-2:0], ack_i};
    end
  end

  assign ack_s_o = sync_q[Depth-1];

endmodule

// File: rtl/est_sync_entrada_seq.sv
// Clocked token source heading the asynchronous pipeline. Emits the arithmetic
// sequence START + idx*STEP (mod 2^WIDTH) over a four-phase bundled-data handshake,
// either once (COUNT tokens, then done) or looping forever.
//   clk    : clock, all state on its rising edge
//   rst_n  : asynchronous active-low reset
//   seq_io : master side of the handshake bundle (en, ack_next in; req_out,
//            data_out, idx, done out; all outputs registered)
module est_sync_entrada_seq
  import est_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned START    = 'h56,
  parameter int unsigned STEP     = 1,
  parameter int unsigned COUNT    = 4,
  parameter int unsigned LOOP     = 0,
  parameter int unsigned ACK_SYNC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  est_sync_entrada_seq_if.master seq_io
);

  localparam int unsigned      IdxW   = idx_width(COUNT);
  localparam logic [WIDTH-1:0] StartW = WIDTH'(START);
  localparam logic [WIDTH-1:0] StepW  = WIDTH'(STEP);
  localparam logic [IdxW-1:0]  IdxMax = IdxW'(COUNT - 1);

  state_e           state_q;
  logic             req_q;
  logic [WIDTH-1:0] data_q;
  logic [IdxW-1:0]  idx_q;
  logic             done_q;

  logic             ack_s;
  logic             idx_last;
  logic [IdxW-1:0]  idx_nxt;
  logic [WIDTH-1:0] tok_nxt;

  est_sync_ack #(
    .Depth (ACK_SYNC)
  ) u_sync_ack (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ack_i   (seq_io.ack_next),
    .ack_s_o (ack_s)
  );

  assign idx_last = (idx_q == IdxMax);
  assign idx_nxt  = idx_last ? '0 : idx_q + IdxW'(1);
  assign tok_nxt  = StartW + WIDTH'(idx_nxt) * StepW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seq_io.en) begin
            idx_q   <= '0;
            data_q  <= StartW;
            state_q <= StSetup;
          end
        end
        // Wait for the previous handshake's ack to be fully low before requesting.
        StSetup: begin
          if (!ack_s) begin
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= StRtz;
          end
        end
        // en is only sampled once the return-to-zero phase has completed.
        StRtz: begin
          if (!ack_s) begin
            if (!seq_io.en) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else if (idx_last && (LOOP == 0)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_nxt;
              data_q  <= tok_nxt;
              state_q <= StSetup;
            end
          end
        end
        StDone: begin
          if (!seq_io.en) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          req_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign seq_io.req_out  = req_q;
  assign seq_io.data_out = data_q;
  assign seq_io.idx      = idx_q;
  assign seq_io.done     = done_q;

endmodule

// File: tb/tb_est_sync_entrada_seq.sv
// Directed bench for est_sync_entrada_seq: one default one-shot instance (A) and one
// looping instance (B: COUNT=3, START=FE). A simple downstream model acks 3 cycles
// after each request and drops ack once the request falls.
module tb_est_sync_entrada_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic en_a = 1'b0, ack_a = 1'b0, hold_a = 1'b0;
  logic en_b = 1'b0, ack_b = 1'b0;
  int   cnt_a = 0, cnt_b = 0;

  est_sync_entrada_seq_if #(.WIDTH(8), .IDX_W(2)) bus_a ();
  est_sync_entrada_seq_if #(.WIDTH(8), .IDX_W(2)) bus_b ();

  assign bus_a.en       = en_a;
  assign bus_a.ack_next = ack_a;
  assign bus_b.en       = en_b;
  assign bus_b.ack_next = ack_b;

  est_sync_entrada_seq u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_io (bus_a)
  );

  est_sync_entrada_seq #(
    .WIDTH    (8),
    .START    ('hFE),
    .STEP     (1),
    .COUNT    (3),
    .LOOP     (1),
    .ACK_SYNC (2)
  ) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_io (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream models
  always begin
    @(posedge clk);
    #1;
    if (!hold_a) begin
      if (!rst_n) begin
        ack_a = 1'b0;
        cnt_a = 0;
      end else if (bus_a.req_out && !ack_a) begin
        cnt_a++;
        if (cnt_a >= 3) begin
          ack_a = 1'b1;
          cnt_a = 0;
        end
      end else if (!bus_a.req_out && ack_a) begin
        ack_a = 1'b0;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ack_b = 1'b0;
      cnt_b = 0;
    end else if (bus_b.req_out && !ack_b) begin
      cnt_b++;
      if (cnt_b >= 3) begin
        ack_b = 1'b1;
        cnt_b = 0;
      end
    end else if (!bus_b.req_out && ack_b) begin
      ack_b = 1'b0;
    end
  end

  // Token capture plus bundling checks: data stable while req=1, data settled
  // at least one cycle before req rises.
  logic [7:0] toks_a[$];
  logic [7:0] toks_b[$];
  int         idxs_b[$];
  logic       rprev_a = 1'b0, rprev_b = 1'b0;
  logic [7:0] dprev_a = '0, dprev_b = '0;
  int         age_a = 0, age_b = 0;

  always @(negedge clk) begin
    if (bus_a.data_out != dprev_a) age_a = 0;
    else age_a++;
    if (bus_a.req_out && rprev_a) check("a_data_stable_in_req", bus_a.data_out, dprev_a);
    if (bus_a.req_out && !rprev_a) begin
      toks_a.push_back(bus_a.data_out);
      check("a_data_before_req", 32'(age_a >= 1), 1);
    end
    rprev_a = bus_a.req_out;
    dprev_a = bus_a.data_out;
  end

  always @(negedge clk) begin
    if (bus_b.data_out != dprev_b) age_b = 0;
    else age_b++;
    if (bus_b.req_out && rprev_b) check("b_data_stable_in_req", bus_b.data_out, dprev_b);
    if (bus_b.req_out && !rprev_b) begin
      toks_b.push_back(bus_b.data_out);
      idxs_b.push_back(int'(bus_b.idx));
      check("b_data_before_req", 32'(age_b >= 1), 1);
    end
    rprev_b = bus_b.req_out;
    dprev_b = bus_b.data_out;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] exp_b[7];
    int         exp_ib[7];
    exp_b  = '{8'hFE, 8'hFF, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'hFE};
    exp_ib = '{0, 1, 2, 0, 1, 2, 0};

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_req", bus_a.req_out, 0);
    check("rst_data", bus_a.data_out, 0);
    check("rst_idx", bus_a.idx, 0);
    check("rst_done", bus_a.done, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    check("idle_req", bus_a.req_out, 0);

    // One-shot sequence on A, looping sequence on B
    en_a = 1'b1;
    en_b = 1'b1;
    n = 0;
    while (bus_a.done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("a_done_reached", bus_a.done, 1);
    check("a_tok_count", toks_a.size(), 4);
    for (int i = 0; i < 4 && i < toks_a.size(); i++)
      check($sformatf("a_tok%0d", i), toks_a[i], 32'h56 + i);
    check("a_done_idx", bus_a.idx, 3);
    check("a_done_data", bus_a.data_out, 8'h59);
    cycles(10);
    check("a_done_req_low", bus_a.req_out, 0);
    check("a_done_no_more_tok", toks_a.size(), 4);
    check("a_done_held", bus_a.done, 1);
    en_a = 1'b0;
    cycles(2);
    check("a_done_cleared", bus_a.done, 0);

    n = 0;
    while (toks_b.size() < 7 && n < 600) begin @(negedge clk); n++; end
    check("b_tok_count", 32'(toks_b.size() >= 7), 1);
    for (int i = 0; i < 7 && i < toks_b.size(); i++) begin
      check($sformatf("b_tok%0d", i), toks_b[i], exp_b[i]);
      check($sformatf("b_idx%0d", i), idxs_b[i], exp_ib[i]);
    end
    check("b_no_done", bus_b.done, 0);
    en_b = 1'b0;

    // Drop en during REQ: handshake completes, then back to IDLE
    toks_a.delete();
    en_a = 1'b1;
    n = 0;
    while (bus_a.req_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("abort_req_seen", bus_a.req_out, 1);
    en_a = 1'b0;
    cycles(3);
    check("abort_req_held", bus_a.req_out, 1);
    cycles(20);
    check("abort_req_low", bus_a.req_out, 0);
    check("abort_idx", bus_a.idx, 0);
    check("abort_one_tok", toks_a.size(), 1);
    check("abort_no_done", bus_a.done, 0);

    // Restart at START, then reset mid-handshake on the second token
    toks_a.delete();
    en_a = 1'b1;
    n = 0;
    while (bus_a.req_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("restart_data", bus_a.data_out, 8'h56);
    check("restart_idx", bus_a.idx, 0);
    n = 0;
    while (!(toks_a.size() >= 2 && bus_a.req_out === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrst_req_before", bus_a.req_out, 1);
    check("midrst_idx_before", bus_a.idx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", bus_a.req_out, 0);
    check("midrst_data", bus_a.data_out, 0);
    check("midrst_idx", bus_a.idx, 0);
    check("midrst_done", bus_a.done, 0);
    en_a = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check("postrst_req", bus_a.req_out, 0);
    check("postrst_data", bus_a.data_out, 0);

    // ack_next held high before start: stay in SETUP with req low
    hold_a = 1'b1;
    ack_a  = 1'b1;
    cycles(5);
    en_a = 1'b1;
    cycles(10);
    check("setup_req_low", bus_a.req_out, 0);
    check("setup_data", bus_a.data_out, 8'h56);
    check("setup_idx", bus_a.idx, 0);
    ack_a  = 1'b0;
    hold_a = 1'b0;
    n = 0;
    while (bus_a.req_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("setup_release_req", bus_a.req_out, 1);
    check("setup_release_data", bus_a.data_out, 8'h56);
    en_a = 1'b0;
    cycles(30);
    check("final_idle_req", bus_a.req_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
